// File: rtl/rmii_link_emulator_if.sv
`default_nettype none
// ============================================================================
// Module   : rmii_link_emulator_if
// Purpose  : Bundles the per-port RMII pins, link/error controls and the
//            statistics counters of the N-port link emulator.
//            master = MAC/bench side, slave = link emulator.
// Revision : 1.0 - initial release
// ============================================================================
interface rmii_link_emulator_if #(
  parameter int N_PORTS = 2,
  parameter int CNT_W   = 16
) ();

  logic [N_PORTS-1:0]       tx_e;
  logic [2*N_PORTS-1:0]     tx_d;
  logic [N_PORTS-1:0]       link_en;
  logic [N_PORTS-1:0]       err_req;
  logic [N_PORTS-1:0]       crs_dv;
  logic [2*N_PORTS-1:0]     rx_d;
  logic [N_PORTS-1:0]       rx_er;
  logic [N_PORTS*CNT_W-1:0] frame_cnt;
  logic [N_PORTS*CNT_W-1:0] drop_cnt;
  logic [N_PORTS*CNT_W-1:0] err_cnt;

  modport master (
    output tx_e, tx_d, link_en, err_req,
    input  crs_dv, rx_d, rx_er, frame_cnt, drop_cnt, err_cnt
  );

  modport slave (
    input  tx_e, tx_d, link_en, err_req,
    output crs_dv, rx_d, rx_er, frame_cnt, drop_cnt, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/rmii_link_emulator.sv
`default_nettype none
// ============================================================================
// Module   : rmii_link_emulator
// Purpose  : N-port RMII link model. Each source port's TX dibit stream is
//            pushed into a fixed-depth delay line and replayed on the RX pins
//            of its destination (next port in a ring, or itself in loopback).
//            Adds per-port link gating, single-dibit error injection and
//            saturating frame / drop / error statistics.
// Revision : 1.0 - initial release
// ============================================================================
module rmii_link_emulator #(
  parameter int N_PORTS      = 2,   // 1..8, must match the interface
  parameter int DELAY_CYCLES = 16,  // 1..256
  parameter int MODE         = 0,   // 0 = ring, 1 = loopback
  parameter int ERR_OFFSET   = 20,  // dibit index corrupted on injection
  parameter int CNT_W        = 16   // statistics counter width, must match the interface
) (
  input  logic                clk_50_mhz,
  input  logic                rst,
  rmii_link_emulator_if.slave bus
);

  localparam int               IDX_W   = 16;
  localparam logic [IDX_W-1:0] ERR_IDX = 16'(ERR_OFFSET);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } src_state_e;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [1:0] dibit;
  } dl_entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  src_state_e       state_q     [N_PORTS];
  logic [IDX_W-1:0] idx_q       [N_PORTS];
  logic [CNT_W-1:0] frame_cnt_q [N_PORTS];
  logic [CNT_W-1:0] drop_cnt_q  [N_PORTS];
  logic [CNT_W-1:0] err_cnt_q   [N_PORTS];
  dl_entry_t        dl_q        [N_PORTS][DELAY_CYCLES];

  // Previous tx_e. Reset to 1 so a port whose tx_e is already high when
  // reset releases must first be seen low before a frame can start.
  logic [N_PORTS-1:0] tx_e_prev_q;
  // Request latched, waiting for the next forwarded frame.
  logic [N_PORTS-1:0] pend_q;
  // Current forwarded frame still owes one corrupted dibit.
  logic [N_PORTS-1:0] frame_err_q;

  // --------------------------------------------------------------------------
  // Per-cycle decode
  // --------------------------------------------------------------------------
  logic [N_PORTS-1:0] frame_start;
  logic [N_PORTS-1:0] frame_end;
  logic [N_PORTS-1:0] fwd_start;
  logic [N_PORTS-1:0] drop_start;
  logic [N_PORTS-1:0] fwd_active;
  logic [N_PORTS-1:0] err_arm;
  logic [N_PORTS-1:0] inject;
  logic [IDX_W-1:0]   idx_cur [N_PORTS];
  dl_entry_t          entry_d [N_PORTS];

  // Frame edge detection, forwarding decision and the delay-line entry for
  // this cycle. The start cycle is forwarded even though the FSM is still
  // IDLE, so index 0 is the first tx_e cycle.
  always_comb begin
    frame_start = '0;
    frame_end   = '0;
    fwd_start   = '0;
    drop_start  = '0;
    fwd_active  = '0;
    err_arm     = '0;
    inject      = '0;
    for (int s = 0; s < N_PORTS; s++) begin
      idx_cur[s] = '0;
      entry_d[s] = '0;

      frame_start[s] = bus.tx_e[s] & ~tx_e_prev_q[s];
      frame_end[s]   = ~bus.tx_e[s] & tx_e_prev_q[s];
      fwd_start[s]   = frame_start[s] & bus.link_en[s];
      drop_start[s]  = frame_start[s] & ~bus.link_en[s];
      fwd_active[s]  = (state_q[s] == ST_FWD) | fwd_start[s];
      idx_cur[s]     = frame_start[s] ? '0 : idx_q[s];

      // A request in the start cycle itself still applies to this frame.
      err_arm[s] = fwd_start[s] ? (pend_q[s] | bus.err_req[s]) : frame_err_q[s];
      inject[s]  = fwd_active[s] & bus.tx_e[s] & err_arm[s] & (idx_cur[s] == ERR_IDX);

      if (fwd_active[s] && bus.tx_e[s]) begin
        entry_d[s].valid = 1'b1;
        entry_d[s].err   = inject[s];
        entry_d[s].dibit = bus.tx_d[2*s +: 2] ^ {2{inject[s]}};
      end
    end
  end

  // Per-port source FSM, dibit index, error bookkeeping, counters and delay
  // lines.
  always_ff @(posedge clk_50_mhz or posedge rst) begin
    if (rst) begin
      tx_e_prev_q <= '1;
      pend_q      <= '0;
      frame_err_q <= '0;
      for (int s = 0; s < N_PORTS; s++) begin
        state_q[s]     <= ST_IDLE;
        idx_q[s]       <= '0;
        frame_cnt_q[s] <= '0;
        drop_cnt_q[s]  <= '0;
        err_cnt_q[s]   <= '0;
        for (int k = 0; k < DELAY_CYCLES; k++) begin
          dl_q[s][k] <= '0;
        end
      end
    end else begin
      tx_e_prev_q <= bus.tx_e;
      for (int s = 0; s < N_PORTS; s++) begin
        // Link state is only looked at in the start cycle, so frames are
        // never truncated or half-forwarded.
        case (state_q[s])
          ST_IDLE: begin
            if (frame_start[s]) begin
              state_q[s] <= bus.link_en[s] ? ST_FWD : ST_DROP;
            end
          end
          ST_FWD, ST_DROP: begin
            if (frame_end[s]) begin
              state_q[s] <= ST_IDLE;
            end
          end
          default: state_q[s] <= ST_IDLE;
        endcase

        if (frame_start[s]) begin
          idx_q[s] <= 16'd1;
        end else if (bus.tx_e[s] && (idx_q[s] != IDX_MAX)) begin
          idx_q[s] <= idx_q[s] + 16'd1;
        end

        // A forwarded frame start consumes the pending request; requests
        // arriving later in the frame wait for the following frame.
        if (fwd_start[s] && (pend_q[s] || bus.err_req[s])) begin
          pend_q[s] <= 1'b0;
        end else begin
          pend_q[s] <= pend_q[s] | bus.err_req[s];
        end

        // The owed corruption is dropped if the frame ends short of it.
        if (fwd_start[s]) begin
          frame_err_q[s] <= err_arm[s] & ~inject[s];
        end else if (inject[s] || frame_end[s]) begin
          frame_err_q[s] <= 1'b0;
        end

        if ((state_q[s] == ST_FWD) && frame_end[s] && (frame_cnt_q[s] != CNT_MAX)) begin
          frame_cnt_q[s] <= frame_cnt_q[s] + 1'b1;
        end
        if (drop_start[s] && (drop_cnt_q[s] != CNT_MAX)) begin
          drop_cnt_q[s] <= drop_cnt_q[s] + 1'b1;
        end
        if (inject[s] && (err_cnt_q[s] != CNT_MAX)) begin
          err_cnt_q[s] <= err_cnt_q[s] + 1'b1;
        end

        dl_q[s][0] <= entry_d[s];
        for (int k = 1; k < DELAY_CYCLES; k++) begin
          dl_q[s][k] <= dl_q[s][k-1];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping: every destination has exactly one source.
  // --------------------------------------------------------------------------
  function automatic int src_of(input int d);
    if (MODE == 1) begin
      return d;
    end
    return (d + N_PORTS - 1) % N_PORTS;
  endfunction

  logic [N_PORTS-1:0]       crs_dv_w;
  logic [2*N_PORTS-1:0]     rx_d_w;
  logic [N_PORTS-1:0]       rx_er_w;
  logic [N_PORTS*CNT_W-1:0] frame_cnt_w;
  logic [N_PORTS*CNT_W-1:0] drop_cnt_w;
  logic [N_PORTS*CNT_W-1:0] err_cnt_w;

  // Route the tail of each source's delay line to its destination pins and
  // flatten the counters.
  always_comb begin
    crs_dv_w    = '0;
    rx_d_w      = '0;
    rx_er_w     = '0;
    frame_cnt_w = '0;
    drop_cnt_w  = '0;
    err_cnt_w   = '0;
    for (int d = 0; d < N_PORTS; d++) begin
      crs_dv_w[d]            = dl_q[src_of(d)][DELAY_CYCLES-1].valid;
      rx_er_w[d]             = dl_q[src_of(d)][DELAY_CYCLES-1].err;
      rx_d_w[2*d +: 2]       = dl_q[src_of(d)][DELAY_CYCLES-1].dibit;
      frame_cnt_w[d*CNT_W +: CNT_W] = frame_cnt_q[d];
      drop_cnt_w[d*CNT_W +: CNT_W]  = drop_cnt_q[d];
      err_cnt_w[d*CNT_W +: CNT_W]   = err_cnt_q[d];
    end
  end

  assign bus.crs_dv    = crs_dv_w;
  assign bus.rx_d      = rx_d_w;
  assign bus.rx_er     = rx_er_w;
  assign bus.frame_cnt = frame_cnt_w;
  assign bus.drop_cnt  = drop_cnt_w;
  assign bus.err_cnt   = err_cnt_w;

endmodule
`default_nettype wire
